// File: rtl/cdc_arb_pkg.sv
// Shared types and constants for the crossing launch-side arbiter.
package cdc_arb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLaunch = 2'd1,
    StWaitHi = 2'd2,
    StWaitLo = 2'd3
  } arb_state_e;

  localparam int unsigned CNT_W = 16;

  // Ceiling log2, never below 1 so index fields always have a bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request after ptr_i, cyclic.
module rr_arbiter
  import cdc_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IdxW   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IdxW-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IdxW-1:0]    idx_o,
  output logic               valid_o
);

  // Scan from the slot after the last winner; the pointer itself is checked last.
  always_comb begin
    int unsigned cand;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = (32'(ptr_i) + off) % NUM_REQ;
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = IdxW'(cand);
      end
    end
  end

endmodule

// File: rtl/cdc_bus_arbiter.sv
// Round-robin sharer for the launch side of a flag/busy toggle-handshake crossing.
// Optional macro CDC_ARB_TAG_EN prepends the winner index to the launched word.
module cdc_bus_arbiter
  import cdc_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8,
  localparam int unsigned TAG_W  = clog2(NUM_REQ),
`ifdef CDC_ARB_TAG_EN
  localparam int unsigned BUS_W  = DATA_W + TAG_W
`else
  localparam int unsigned BUS_W  = DATA_W
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      busy_i,
  output logic                      flag_o,
  output logic [BUS_W-1:0]          bus_o,
  output logic [CNT_W-1:0]          xfer_cnt
);

  arb_state_e         state_q;
  logic [TAG_W-1:0]   ptr_q;
  logic [BUS_W-1:0]   bus_q;
  logic               flag_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [NUM_REQ-1:0] gnt;
  logic [TAG_W-1:0]   win_idx;
  logic               win_valid;
  logic               grant_en;
  logic [DATA_W-1:0]  win_data;
  logic [BUS_W-1:0]   cap_word;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .gnt_o   (gnt),
    .idx_o   (win_idx),
    .valid_o (win_valid)
  );

  // Grant only from IDLE with the crossing quiet; a stale busy blocks new launches.
  always_comb begin
    grant_en  = (state_q == StIdle) && !busy_i && !rst && win_valid;
    req_ready = grant_en ? gnt : '0;
    win_data  = req_data[win_idx*DATA_W +: DATA_W];
`ifdef CDC_ARB_TAG_EN
    cap_word  = {win_idx, win_data};
`else
    cap_word  = win_data;
`endif
  end

  // Handshake FSM with registered launch flag and captured word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      flag_q  <= 1'b0;
      bus_q   <= '0;
      ptr_q   <= TAG_W'(NUM_REQ - 1);
    end else begin
      flag_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_en) begin
            bus_q   <= cap_word;
            ptr_q   <= win_idx;
            flag_q  <= 1'b1;
            state_q <= StLaunch;
          end
        end
        StLaunch: state_q <= StWaitHi;
        StWaitHi: if (busy_i) state_q <= StWaitLo;
        StWaitLo: if (!busy_i) state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  // A transfer completes when busy falls while waiting for it; counter wraps freely.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == StWaitLo) && !busy_i) cnt_d = cnt_q + CNT_W'(1);
  end

  // Completed-transfer counter.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign flag_o   = flag_q;
  assign bus_o    = bus_q;
  assign xfer_cnt = cnt_q;

endmodule

// File: tb/tb_cdc_bus_arbiter.sv
// Directed bench for cdc_bus_arbiter; the bench drives busy_i as the crossing would.
module tb_cdc_bus_arbiter;

`ifdef CDC_ARB_TAG_EN
  localparam int unsigned BusW = 10;
`else
  localparam int unsigned BusW = 8;
`endif

  logic            clk;
  logic            rst;
  logic [3:0]      req_valid;
  logic [31:0]     req_data;
  logic [3:0]      req_ready;
  logic            busy_i;
  logic            flag_o;
  logic [BusW-1:0] bus_o;
  logic [15:0]     xfer_cnt;

  int unsigned chk_cnt  = 0;
  int unsigned pass_cnt = 0;
  int unsigned fail_cnt = 0;

  // Per-requester payloads: req0=71, req1=5C, req2=A5, req3=D3.
  logic [7:0] dat [4];

  cdc_bus_arbiter #(
    .NUM_REQ (4),
    .DATA_W  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .busy_i    (busy_i),
    .flag_o    (flag_o),
    .bus_o     (bus_o),
    .xfer_cnt  (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_word(input logic [1:0] idx, input logic [7:0] d);
`ifdef CDC_ARB_TAG_EN
    return {22'd0, idx, d};
`else
    return {24'd0, d};
`endif
  endfunction

  // Full transfer from an IDLE cycle whose inputs are already applied.
  task automatic xfer(input logic [1:0] idx, input int hold, input logic [3:0] valid_after,
                      input logic [15:0] exp_cnt);
    logic [3:0] onehot;
    onehot = 4'b0001 << idx;
    #1;
    chk("grant_ready", 32'(req_ready), 32'(onehot));
    chk("grant_noflag", 32'(flag_o), 32'd0);
    cyc();
    req_valid = valid_after;
    #1;
    chk("launch_flag", 32'(flag_o), 32'd1);
    chk("launch_bus", 32'(bus_o), exp_word(idx, dat[idx]));
    chk("launch_ready", 32'(req_ready), 32'd0);
    cyc();
    chk("waithi_flag", 32'(flag_o), 32'd0);
    chk("waithi_bus", 32'(bus_o), exp_word(idx, dat[idx]));
    busy_i = 1'b1;
    cyc();
    for (int k = 1; k < hold; k++) cyc();
    busy_i = 1'b0;
    #1;
    chk("waitlo_ready", 32'(req_ready), 32'd0);
    cyc();
    chk("xfer_cnt", 32'(xfer_cnt), 32'(exp_cnt));
  endtask

  initial begin
    dat[0] = 8'h71;
    dat[1] = 8'h5C;
    dat[2] = 8'hA5;
    dat[3] = 8'hD3;
    req_data  = 32'hD3A55C71;
    rst       = 1'b1;
    req_valid = 4'hF;
    busy_i    = 1'b0;

    // 1: reset held 3 cycles with all requesters valid
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_flag", 32'(flag_o), 32'd0);
      chk("rst_bus", 32'(bus_o), 32'd0);
      chk("rst_cnt", 32'(xfer_cnt), 32'd0);
    end
    req_valid = 4'h0;
    rst = 1'b0;

    // 2: idle with nothing valid, then single request from req 2
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("idle_ready", 32'(req_ready), 32'd0);
      chk("idle_flag", 32'(flag_o), 32'd0);
    end
    req_valid = 4'b0100;
    xfer(2'd2, 3, 4'b0000, 16'd1);

    // 3: fairness from a fresh reset (pointer back to 3, so req 0 first)
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst2_cnt", 32'(xfer_cnt), 32'd0);
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) xfer(2'(k % 4), 2, 4'hF, 16'(k + 1));

    // 4: stale busy blocks grants in IDLE
    req_valid = 4'b0001;
    busy_i    = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stale_ready", 32'(req_ready), 32'd0);
      chk("stale_flag", 32'(flag_o), 32'd0);
      cyc();
    end
    busy_i = 1'b0;
    xfer(2'd0, 2, 4'b0000, 16'd9);

    // 5: reset while in WAIT_LO, then req 1 transfers normally
    req_valid = 4'b0100;
    #1;
    chk("mid_ready", 32'(req_ready), 32'b0100);
    cyc();
    req_valid = 4'b0000;
    cyc();
    busy_i = 1'b1;
    cyc();
    cyc();
    rst    = 1'b1;
    busy_i = 1'b0;
    cyc();
    rst = 1'b0;
    chk("midrst_flag", 32'(flag_o), 32'd0);
    chk("midrst_cnt", 32'(xfer_cnt), 32'd0);
    chk("midrst_bus", 32'(bus_o), 32'd0);
    req_valid = 4'b0010;
    xfer(2'd1, 2, 4'b0000, 16'd1);

    // 6: counter preloaded to FFFF wraps to 0 on the next completion
    force dut.cnt_q = 16'hFFFF;
    cyc();
    release dut.cnt_q;
    #1;
    chk("preload_cnt", 32'(xfer_cnt), 32'h0000FFFF);
    req_valid = 4'b1000;
    xfer(2'd3, 2, 4'b0000, 16'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  // Global time bound so a stuck run still ends.
  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
